// File: rtl/fnv_stream_sequencer_pkg.sv
// Shared FNV-1a constants and the sequencer state type.
// The hasher core and the sequencer both import this package.
package fnv_pkg;

  localparam int          DigestWidth    = 32;
  localparam logic [31:0] FnvOffsetBasis = 32'h811C9DC5;
  localparam logic [31:0] FnvPrime       = 32'h01000193;

  typedef enum logic [1:0] {
    CLEAR,
    ABSORB,
    CAPTURE,
    EMIT
  } seq_state_t;

endpackage

// File: rtl/fnv_stream_sequencer_if.sv
// Bundles the byte-in, hasher-side and digest-out handshakes of the sequencer.
// "slave" is the sequencer's view; "master" is the surrounding logic's view.
interface fnv_stream_sequencer_if #(
  parameter int LenWidth = 16
);
  import fnv_pkg::*;

  logic                   in_valid;
  logic [7:0]             in_data;
  logic                   in_last;
  logic                   in_flush;
  logic                   in_ready;
  logic                   hash_clear;
  logic                   hash_enable;
  logic [7:0]             hash_byte;
  logic [DigestWidth-1:0] hash_value;
  logic                   out_valid;
  logic [7:0]             out_data;
  logic                   out_last;
  logic                   out_ready;
  logic [LenWidth-1:0]    msg_len;

  modport slave (
    input  in_valid, in_data, in_last, in_flush, hash_value, out_ready,
    output in_ready, hash_clear, hash_enable, hash_byte,
           out_valid, out_data, out_last, msg_len
  );

  modport master (
    output in_valid, in_data, in_last, in_flush, hash_value, out_ready,
    input  in_ready, hash_clear, hash_enable, hash_byte,
           out_valid, out_data, out_last, msg_len
  );

endinterface

// File: rtl/fnv_hasher_core.sv
// 32-bit FNV-1a hasher: xor the byte in, then multiply by the FNV prime.
// Synchronous clear returns the state to the offset basis.
module fnv_hasher_core
  import fnv_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic                   enable,
  input  logic [7:0]             data_in,
  output logic [DigestWidth-1:0] hash_out
);

  logic [DigestWidth-1:0] hash_q, hash_d;

  always_comb begin
    hash_d = hash_q;
    if (clear) begin
      hash_d = FnvOffsetBasis;
    end else if (enable) begin
      hash_d = (hash_q ^ {24'd0, data_in}) * FnvPrime;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hash_q <= FnvOffsetBasis;
    end else begin
      hash_q <= hash_d;
    end
  end

  assign hash_out = hash_q;

endmodule

// File: rtl/fnv_stream_sequencer_serializer.sv
// Snapshots the digest and returns it one byte per handshake, MSB byte first.
// The output handshake is held stable until the downstream accepts.
module fnv_digest_serializer
  import fnv_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load,
  input  logic [DigestWidth-1:0] snapshot,
  input  logic                   out_ready,
  output logic                   out_valid,
  output logic [7:0]             out_data,
  output logic                   out_last,
  output logic                   done
);

  logic [DigestWidth-1:0] snap_q, snap_d;
  logic [1:0]             idx_q, idx_d;
  logic                   valid_q, valid_d;
  logic [1:0]             byte_sel;

  always_comb begin
    snap_d  = snap_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    if (load) begin
      snap_d  = snapshot;
      idx_d   = 2'd0;
      valid_d = 1'b1;
    end else if (valid_q && out_ready) begin
      idx_d = idx_q + 2'd1;
      if (idx_q == 2'd3) begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_q  <= '0;
      idx_q   <= 2'd0;
      valid_q <= 1'b0;
    end else begin
      snap_q  <= snap_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
    end
  end

  // Byte 0 of the digest is bits 31:24.
  assign byte_sel  = 2'd3 - idx_q;
  assign out_data  = snap_q[{byte_sel, 3'b000} +: 8];
  assign out_valid = valid_q;
  assign out_last  = valid_q && (idx_q == 2'd3);
  assign done      = valid_q && out_ready && (idx_q == 2'd3);

endmodule

// File: rtl/fnv_stream_sequencer.sv
// Control stage in front of the FNV-1a hasher: clears it, feeds the framed
// byte stream into it, then hands the final digest to the serializer.
module fnv_stream_sequencer
  import fnv_pkg::*;
#(
  parameter int DigestBytes = 4,
  parameter int LenWidth    = 16
) (
  input logic                   clk,
  input logic                   rst_n,
  fnv_stream_sequencer_if.slave bus
);

  if (DigestBytes != 4) begin : g_bad_digest_bytes
    $error("fnv_stream_sequencer: DigestBytes must be 4");
  end

  seq_state_t          state_q, state_d;
  logic [LenWidth-1:0] len_q, len_d;
  logic                load;
  logic                done;
  logic                in_ready;
  logic                hash_clear;
  logic                hash_enable;
  logic [7:0]          hash_byte;

  // in_ready depends only on state; hash_enable/hash_byte pass through in ABSORB.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    load        = 1'b0;
    in_ready    = 1'b0;
    hash_clear  = 1'b0;
    hash_enable = 1'b0;
    hash_byte   = 8'd0;
    unique case (state_q)
      CLEAR: begin
        hash_clear = 1'b1;
        len_d      = '0;
        state_d    = ABSORB;
      end
      ABSORB: begin
        in_ready    = 1'b1;
        hash_enable = bus.in_valid;
        hash_byte   = bus.in_data;
        if (bus.in_valid && (len_q != {LenWidth{1'b1}})) begin
          len_d = len_q + 1'b1;
        end
        if ((bus.in_valid && bus.in_last) || bus.in_flush) begin
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        load    = 1'b1;
        state_d = EMIT;
      end
      EMIT: begin
        if (done) begin
          state_d = CLEAR;
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CLEAR;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
    end
  end

  fnv_digest_serializer u_serializer (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .snapshot  (bus.hash_value),
    .out_ready (bus.out_ready),
    .out_valid (bus.out_valid),
    .out_data  (bus.out_data),
    .out_last  (bus.out_last),
    .done      (done)
  );

  assign bus.in_ready    = in_ready;
  assign bus.hash_clear  = hash_clear;
  assign bus.hash_enable = hash_enable;
  assign bus.hash_byte   = hash_byte;
  assign bus.msg_len     = len_q;

endmodule
